// File: rtl/seg_pkg.sv
// Shared symbol codes and active-low segment patterns for the seven-segment display path.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seg_pkg;

    localparam int SYM_W = 5;
    localparam int SEG_W = 7;

    // Symbol codes
    localparam logic [SYM_W-1:0] SYM_ZERO          = 5'd0;
    localparam logic [SYM_W-1:0] SYM_ONE           = 5'd1;
    localparam logic [SYM_W-1:0] SYM_TWO           = 5'd2;
    localparam logic [SYM_W-1:0] SYM_THREE         = 5'd3;
    localparam logic [SYM_W-1:0] SYM_FOUR          = 5'd4;
    localparam logic [SYM_W-1:0] SYM_FIVE          = 5'd5;
    localparam logic [SYM_W-1:0] SYM_SIX           = 5'd6;
    localparam logic [SYM_W-1:0] SYM_SEVEN         = 5'd7;
    localparam logic [SYM_W-1:0] SYM_EIGHT         = 5'd8;
    localparam logic [SYM_W-1:0] SYM_NINE          = 5'd9;
    localparam logic [SYM_W-1:0] ARROW_UP          = 5'd10;
    localparam logic [SYM_W-1:0] ARROW_DOWN        = 5'd11;
    localparam logic [SYM_W-1:0] ARROW_LEFT        = 5'd12;
    localparam logic [SYM_W-1:0] ARROW_RIGHT       = 5'd13;
    localparam logic [SYM_W-1:0] ARROW_UP_DOWN     = 5'd14;
    localparam logic [SYM_W-1:0] ARROW_UP_LEFT     = 5'd15;
    localparam logic [SYM_W-1:0] ARROW_UP_RIGHT    = 5'd16;
    localparam logic [SYM_W-1:0] ARROW_DOWN_LEFT   = 5'd17;
    localparam logic [SYM_W-1:0] ARROW_DOWN_RIGHT  = 5'd18;
    localparam logic [SYM_W-1:0] ARROW_LEFT_RIGHT  = 5'd19;
    localparam logic [SYM_W-1:0] ARROW_NONE        = 5'd20;

    // Active-low segment patterns, ordered {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_ZERO  = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_ONE   = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_TWO   = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_THREE = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_FOUR  = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_FIVE  = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_SIX   = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_SEVEN = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_EIGHT = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_NINE  = 7'b0010000;

    localparam logic [SEG_W-1:0] SEG_ARROW_UP    = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_ARROW_DOWN  = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_ARROW_LEFT  = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_ARROW_RIGHT = 7'b1111001;
    // Combined glyphs light the union of segments, i.e. AND of active-low patterns
    localparam logic [SEG_W-1:0] SEG_ARROW_UP_DOWN    = SEG_ARROW_UP   & SEG_ARROW_DOWN;
    localparam logic [SEG_W-1:0] SEG_ARROW_UP_LEFT    = SEG_ARROW_UP   & SEG_ARROW_LEFT;
    localparam logic [SEG_W-1:0] SEG_ARROW_UP_RIGHT   = SEG_ARROW_UP   & SEG_ARROW_RIGHT;
    localparam logic [SEG_W-1:0] SEG_ARROW_DOWN_LEFT  = SEG_ARROW_DOWN & SEG_ARROW_LEFT;
    localparam logic [SEG_W-1:0] SEG_ARROW_DOWN_RIGHT = SEG_ARROW_DOWN & SEG_ARROW_RIGHT;
    localparam logic [SEG_W-1:0] SEG_ARROW_LEFT_RIGHT = SEG_ARROW_LEFT & SEG_ARROW_RIGHT;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg_decoder.sv
// Maps a 5-bit symbol code to an active-low {g,f,e,d,c,b,a} segment pattern.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; output follows input every cycle.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [SYM_W-1:0] code_i,
    output logic [SEG_W-1:0] seg_o
);

    // Table lookup; blank and every illegal code fall through to all segments off
    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            SYM_ZERO:         seg_o = SEG_ZERO;
            SYM_ONE:          seg_o = SEG_ONE;
            SYM_TWO:          seg_o = SEG_TWO;
            SYM_THREE:        seg_o = SEG_THREE;
            SYM_FOUR:         seg_o = SEG_FOUR;
            SYM_FIVE:         seg_o = SEG_FIVE;
            SYM_SIX:          seg_o = SEG_SIX;
            SYM_SEVEN:        seg_o = SEG_SEVEN;
            SYM_EIGHT:        seg_o = SEG_EIGHT;
            SYM_NINE:         seg_o = SEG_NINE;
            ARROW_UP:         seg_o = SEG_ARROW_UP;
            ARROW_DOWN:       seg_o = SEG_ARROW_DOWN;
            ARROW_LEFT:       seg_o = SEG_ARROW_LEFT;
            ARROW_RIGHT:      seg_o = SEG_ARROW_RIGHT;
            ARROW_UP_DOWN:    seg_o = SEG_ARROW_UP_DOWN;
            ARROW_UP_LEFT:    seg_o = SEG_ARROW_UP_LEFT;
            ARROW_UP_RIGHT:   seg_o = SEG_ARROW_UP_RIGHT;
            ARROW_DOWN_LEFT:  seg_o = SEG_ARROW_DOWN_LEFT;
            ARROW_DOWN_RIGHT: seg_o = SEG_ARROW_DOWN_RIGHT;
            ARROW_LEFT_RIGHT: seg_o = SEG_ARROW_LEFT_RIGHT;
            default:          seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Scans a 4-digit common-anode display, one digit per scan_tick, with frame-level shadowing of symbols.
// Latency: 1 cycle from a sampled tick to updated an/seg/dp; sym_in becomes visible within 4 ticks.
// Backpressure: none; every tick is consumed, back-to-back ticks advance one digit per cycle.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SYM_BITS   = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           scan_tick,
    input  logic                           blink_clk,
    input  logic [NUM_DIGITS*SYM_BITS-1:0] sym_in,
    input  logic [NUM_DIGITS-1:0]          blink_mask,
    input  logic [NUM_DIGITS-1:0]          dp_mask,
    output logic [NUM_DIGITS-1:0]          an,
    output logic [SEG_W-1:0]               seg,
    output logic                           dp
);

    localparam logic [1:0] LAST_IDX = 2'd3;

    logic [1:0]                     idx_q, idx_d;
    logic [NUM_DIGITS*SYM_BITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]          an_q, an_d;
    logic [SEG_W-1:0]               seg_q, seg_d;
    logic                           dp_q, dp_d;

    logic [1:0]                     idx_nxt;
    logic [NUM_DIGITS*SYM_BITS-1:0] frame_nxt;
    logic [SYM_BITS-1:0]            cur_sym;
    logic [SEG_W-1:0]               cur_seg;
    logic                           cur_blink;
    logic                           cur_dp;

    // Select the digit that the next tick will show; on the wrap the fresh frame is used directly
    always_comb begin
        idx_nxt   = idx_q + 2'd1;
        frame_nxt = (idx_q == LAST_IDX) ? sym_in : shadow_q;
        cur_sym   = frame_nxt[SYM_BITS-1:0];
        cur_blink = 1'b0;
        cur_dp    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nxt == i[1:0]) begin
                cur_sym   = frame_nxt[i*SYM_BITS +: SYM_BITS];
                cur_blink = blink_mask[i];
                cur_dp    = dp_mask[i];
            end
        end
    end

    seg_decoder u_dec (
        .code_i (cur_sym),
        .seg_o  (cur_seg)
    );

    // Next-state: everything holds unless a tick arrives
    always_comb begin
        idx_d    = idx_q;
        shadow_d = shadow_q;
        an_d     = an_q;
        seg_d    = seg_q;
        dp_d     = dp_q;
        if (scan_tick) begin
            idx_d    = idx_nxt;
            shadow_d = frame_nxt;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_d[i] = (idx_nxt != i[1:0]);
            end
            // Blinking blanks segments and dp but keeps the anode driven for even brightness timing
            if (cur_blink && blink_clk) begin
                seg_d = SEG_BLANK;
                dp_d  = 1'b1;
            end else begin
                seg_d = cur_seg;
                dp_d  = ~cur_dp;
            end
        end
    end

    // State and output registers; reset wins over a coincident tick
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= LAST_IDX;
            shadow_q <= {NUM_DIGITS{ARROW_NONE}};
            an_q     <= '1;
            seg_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
        end else begin
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: directed scenarios plus randomized traffic against a reference model.
// Latency: model expects outputs to update on the edge that samples the tick.
// Backpressure: n/a.
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        scan_tick = 1'b0;
    logic        blink_clk = 1'b0;
    logic [19:0] sym_in = '0;
    logic [3:0]  blink_mask = '0;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state: digit position shown, and the latched frame of codes
    int         m_pos;
    logic [4:0] m_frame [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;

    seg_scan_mux #(.NUM_DIGITS(4), .SYM_BITS(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .scan_tick  (scan_tick),
        .blink_clk  (blink_clk),
        .sym_in     (sym_in),
        .blink_mask (blink_mask),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference glyph table: digits listed directly, arrow pairs built by enumerating pairs
    function automatic logic [6:0] ref_decode(input int c);
        logic [6:0] digits [10];
        logic [6:0] base [4];
        int k;
        digits = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                   7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        base   = '{7'b1111110, 7'b1110111, 7'b1001111, 7'b1111001};
        if (c < 10) return digits[c];
        if (c < 14) return base[c-10];
        k = 14;
        for (int a = 0; a < 3; a++) begin
            for (int b = a + 1; b < 4; b++) begin
                if (k == c) return base[a] & base[b];
                k++;
            end
        end
        return 7'h7F;
    endfunction

    task automatic model_reset();
        m_pos = 3;
        for (int k = 0; k < 4; k++) m_frame[k] = 5'd20;
        exp_an  = 4'b1111;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
    endtask

    task automatic model_tick();
        m_pos = (m_pos + 1) % 4;
        if (m_pos == 0) begin
            for (int k = 0; k < 4; k++) m_frame[k] = sym_in[k*5 +: 5];
        end
        exp_an = 4'b1111;
        exp_an[m_pos] = 1'b0;
        if (blink_mask[m_pos] && blink_clk) begin
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
        end else begin
            exp_seg = ref_decode(int'(m_frame[m_pos]));
            exp_dp  = !dp_mask[m_pos];
        end
    endtask

    // One clock: drive controls at negedge, advance model at posedge, compare shortly after
    task automatic step(input logic t, input logic r);
        @(negedge clk);
        scan_tick = t;
        rst       = r;
        @(posedge clk);
        if (r) model_reset();
        else if (t) model_tick();
        #1;
        chk("an", {28'd0, an}, {28'd0, exp_an});
        chk("seg", {25'd0, seg}, {25'd0, exp_seg});
        chk("dp", {31'd0, dp}, {31'd0, exp_dp});
        chk("an_onehot", {31'd0, ($countones(~an) <= 1)}, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0);
    endtask

    function automatic logic [19:0] pack4(input int d3, input int d2, input int d1, input int d0);
        return {d3[4:0], d2[4:0], d1[4:0], d0[4:0]};
    endfunction

    initial begin
        logic [3:0] an_seq [4];
        logic [6:0] seg_seq [4];
        an_seq  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_seq = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000};
        model_reset();

        // Reset and first frame
        sym_in = pack4(3, 2, 1, 0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
        chk("rst_an", {28'd0, an}, 32'h0000000F);
        chk("rst_seg", {25'd0, seg}, 32'h0000007F);
        chk("rst_dp", {31'd0, dp}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0);
            chk("frame1_an", {28'd0, an}, {28'd0, an_seq[k]});
            chk("frame1_seg", {25'd0, seg}, {25'd0, seg_seq[k]});
            idle(9);
        end

        // Frame buffering: mid-frame sym_in change stays hidden until the wrap
        step(1'b0, 1'b1);
        sym_in = pack4(7, 6, 9, 8);
        step(1'b1, 1'b0);
        chk("buf_d0_old", {25'd0, seg}, 32'h00000000);
        step(1'b1, 1'b0);
        chk("buf_d1", {25'd0, seg}, {25'd0, 7'b0010000});
        sym_in = pack4(1, 1, 9, 5);
        step(1'b1, 1'b0);
        chk("buf_d2_old", {25'd0, seg}, {25'd0, 7'b0000010});
        step(1'b1, 1'b0);
        chk("buf_d3_old", {25'd0, seg}, {25'd0, 7'b1111000});
        step(1'b1, 1'b0);
        chk("buf_d0_new", {25'd0, seg}, {25'd0, 7'b0010010});

        // Arrows and illegal code
        step(1'b0, 1'b1);
        sym_in = pack4(27, 19, 14, 10);
        step(1'b1, 1'b0); chk("arrow10", {25'd0, seg}, {25'd0, 7'b1111110});
        step(1'b1, 1'b0); chk("arrow14", {25'd0, seg}, {25'd0, 7'b1110110});
        step(1'b1, 1'b0); chk("arrow19", {25'd0, seg}, {25'd0, 7'b1001001});
        step(1'b1, 1'b0); chk("illegal27", {25'd0, seg}, {25'd0, 7'b1111111});

        // Blink and decimal point on digit 1
        step(1'b0, 1'b1);
        sym_in     = pack4(20, 20, 8, 20);
        blink_mask = 4'b0010;
        dp_mask    = 4'b0010;
        blink_clk  = 1'b0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("blink0_seg", {25'd0, seg}, 32'h00000000);
        chk("blink0_dp", {31'd0, dp}, 32'd0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        blink_clk = 1'b1;
        step(1'b1, 1'b0);
        chk("blink1_seg", {25'd0, seg}, 32'h0000007F);
        chk("blink1_dp", {31'd0, dp}, 32'd1);
        chk("blink1_an", {28'd0, an}, {28'd0, 4'b1101});
        blink_mask = '0;
        dp_mask    = '0;
        blink_clk  = 1'b0;

        // Mid-frame reset then back-to-back ticks
        step(1'b0, 1'b1);
        sym_in = pack4(3, 2, 1, 0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
        chk("pre_rst_an", {28'd0, an}, {28'd0, 4'b1011});
        step(1'b0, 1'b1);
        chk("midrst_an", {28'd0, an}, 32'h0000000F);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0);
            chk("b2b_an", {28'd0, an}, {28'd0, an_seq[k]});
        end

        // Reset has priority over a coincident tick and does not advance the index
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("prio_an", {28'd0, an}, 32'h0000000F);
        chk("prio_seg", {25'd0, seg}, 32'h0000007F);
        step(1'b1, 1'b0);
        chk("prio_next_an", {28'd0, an}, {28'd0, 4'b1110});

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < 4; k++) sym_in[k*5 +: 5] = 5'($urandom_range(0, 31));
            end
            blink_mask = 4'($urandom);
            dp_mask    = 4'($urandom);
            blink_clk  = 1'($urandom);
            step(1'($urandom_range(0, 2) != 0), ($urandom_range(0, 99) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
